instruction_memory_loader: RTL and testbench

- Write-side counterpart to the read-only instruction memory.
- Receives a program as a big-endian byte stream over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit instruction word.
- Writes each word to the instruction memory write port at consecutive word addresses starting at 0.
- Holds the processor while a load is in progress and flags completion.

---
 rtl/instruction_memory_loader_if.sv | 30 +++
 rtl/instruction_memory_loader.sv | 92 +++++++++
 tb/tb_instruction_memory_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream and instruction-memory write bundle for the instruction memory loader.
// A byte moves on every rising edge where byteValid and byteReady are both high;
// byteIn must stay stable while byteValid is high and byteReady is low.
interface instruction_memory_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  start;
  logic [ADDR_WIDTH:0]   wordCount;
  logic [7:0]            byteIn;
  logic                  byteValid;
  logic                  byteReady;
  logic                  memWriteEnable;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [31:0]           memWriteData;
  logic                  cpuHold;
  logic                  loadDone;
  logic                  overflowError;

  modport master (
    output start, wordCount, byteIn, byteValid,
    input  byteReady, memWriteEnable, memAddress, memWriteData,
           cpuHold, loadDone, overflowError
  );

  modport slave (
    input  start, wordCount, byteIn, byteValid,
    output byteReady, memWriteEnable, memAddress, memWriteData,
           cpuHold, loadDone, overflowError
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to
// consecutive instruction memory addresses from 0, holding the CPU meanwhile.
module instruction_memory_loader #(
  parameter int WORD_COUNT = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  instruction_memory_loader_if.slave    bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] word_idx;
  logic [ADDR_WIDTH:0] word_next;
  logic [1:0]          byte_idx;
  logic [31:0]         asm_q;
  logic                ovf_q;

  logic start_seen;
  logic too_big;
  logic is_zero;
  logic xfer;

  assign start_seen = bus.start && (state_q == IDLE || state_q == DONE);
  assign too_big    = bus.wordCount > (ADDR_WIDTH+1)'(WORD_COUNT);
  assign is_zero    = bus.wordCount == '0;
  assign xfer       = (state_q == RECV) && bus.byteValid;
  assign word_next  = word_idx + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_seen && !too_big) state_d = is_zero ? DONE : RECV;
      end
      RECV: begin
        if (xfer && byte_idx == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        state_d = (word_next == count_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: word count latch, indices and assembly shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= start_seen && too_big;
      if (start_seen && !too_big && !is_zero) begin
        count_q  <= bus.wordCount;
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (xfer) begin
        asm_q    <= {asm_q[23:0], bus.byteIn};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state_q == WRITE) word_idx <= word_next;
    end
  end

  // Outputs: strobes decode from state, address/data come straight from registers
  always_comb begin
    bus.byteReady      = (state_q == RECV);
    bus.memWriteEnable = (state_q == WRITE);
    bus.cpuHold        = (state_q == RECV) || (state_q == WRITE);
    bus.loadDone       = (state_q == DONE);
    bus.memAddress     = word_idx[ADDR_WIDTH-1:0];
    bus.memWriteData   = asm_q;
    bus.overflowError  = ovf_q;
    dbg_state          = state_q;
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench: random byte streams checked against a word-packing
// reference model and a scoreboard of expected memory writes.
module tb_instruction_memory_loader;

  localparam int WC = 1024;
  localparam int AW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  instruction_memory_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_memory_loader #(.WORD_COUNT(WC), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [AW+31:0] obs_q[$];
  logic [AW+31:0] exp_q[$];
  logic [7:0]     tx_q[$];
  int             gap_q[$];
  logic [31:0]    mem [0:WC-1];
  int             dbl_we = 0;
  logic           prev_we = 1'b0;

  // Memory model / write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.memWriteEnable === 1'b1) begin
      obs_q.push_back({bus.memAddress, bus.memWriteData});
      mem[bus.memAddress] = bus.memWriteData;
      if (prev_we) dbl_we++;
    end
    prev_we = (bus.memWriteEnable === 1'b1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.wordCount = '0;
    bus.byteIn = '0;
    bus.byteValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  task automatic build_exp(input int n);
    exp_q = {};
    for (int i = 0; i < n; i++)
      exp_q.push_back({AW'(i), tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]});
  endtask

  task automatic fill_random(input int nbytes, input bit gaps);
    tx_q = {};
    gap_q = {};
    for (int i = 0; i < nbytes; i++) begin
      tx_q.push_back(8'($urandom_range(0, 255)));
      if (gaps && $urandom_range(0, 3) == 0) gap_q.push_back($urandom_range(1, 3));
      else gap_q.push_back(0);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_load(input int n, output int c0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.wordCount = (AW+1)'(n);
    c0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called on a falling edge; returns just after the edge accepting the last byte.
  task automatic stream();
    int idx = 0;
    int gap = gap_q[0];
    int guard = 0;
    bit acc;
    while (idx < tx_q.size() && guard < 30000) begin
      acc = 1'b0;
      if (gap > 0) begin
        bus.byteValid = 1'b0;
        gap--;
      end else begin
        bus.byteValid = 1'b1;
        bus.byteIn = tx_q[idx];
        acc = (bus.byteReady === 1'b1);
      end
      @(posedge clk);
      if (acc) begin
        idx++;
        if (idx < tx_q.size()) gap = gap_q[idx];
      end
      if (idx < tx_q.size()) @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (idx != tx_q.size()) begin
      n_fail++;
      $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx, tx_q.size());
    end
    #1 bus.byteValid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output logic hold_prev);
    logic ok = 1'b0;
    hold_prev = 1'b0;
    dcyc = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.loadDone === 1'b1) begin
        ok = 1'b1;
        dcyc = cyc;
      end else begin
        hold_prev = bus.cpuHold;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: loadDone=%b after %0d cycles, required 1", bus.loadDone, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.wordCount = '0;
    bus.byteIn = '0;
    bus.byteValid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.byteReady, bus.memWriteEnable, bus.memAddress, bus.memWriteData,
         bus.cpuHold, bus.loadDone, bus.overflowError} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h hold=%b done=%b ovf=%b, required all 0",
               bus.byteReady, bus.memWriteEnable, bus.memAddress, bus.memWriteData,
               bus.cpuHold, bus.loadDone, bus.overflowError);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic(input bit stall);
    int c0, dcyc, want;
    logic hold_prev;
    obs_q = {};
    dbl_we = 0;
    tx_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    gap_q = {0, 0, 0, 0, 0, 0, 0, 0};
    if (stall) gap_q[2] = 3;
    want = stall ? 13 : 10;
    build_exp(2);
    start_load(2, c0);
    stream();
    wait_done(60, dcyc, hold_prev);
    n_cmp++;
    if (dcyc - (c0 + 1) != want) begin
      n_fail++;
      $display("FAIL load_latency: %0d cycles, required %0d", dcyc - (c0 + 1), want);
    end
    n_cmp++;
    if (hold_prev !== 1'b1 || bus.cpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_fall: before=%b at_done=%b, required 1 then 0", hold_prev, bus.cpuHold);
    end
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_write_count: %0d writes, required 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_q.size() > 0 && obs_q[0][31:0] !== 32'h20080005) begin
      n_fail++;
      $display("FAIL word0_value: got %h, required 20080005", obs_q[0][31:0]);
    end
    n_cmp++;
    if (dbl_we != 0) begin
      n_fail++;
      $display("FAIL we_pulse: %0d multi-cycle strobes, required 0", dbl_we);
    end
  endtask

  task automatic test_zero_overflow();
    do_reset();
    obs_q = {};
    @(negedge clk);
    bus.start = 1'b1;
    bus.wordCount = 11'd1025;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.overflowError !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pulse: overflowError=%b, required 1", bus.overflowError);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.overflowError, bus.loadDone, bus.cpuHold, bus.byteReady} !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_idle: ovf=%b done=%b hold=%b rdy=%b, required 0000",
               bus.overflowError, bus.loadDone, bus.cpuHold, bus.byteReady);
    end
    bus.start = 1'b1;
    bus.wordCount = '0;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.loadDone !== 1'b1 || bus.cpuHold !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: done=%b hold=%b, required 1 0", bus.loadDone, bus.cpuHold);
    end
    // Oversized start from DONE is rejected and leaves loadDone set
    bus.start = 1'b1;
    bus.wordCount = 11'd1500;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.overflowError !== 1'b1 || bus.loadDone !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_from_done: ovf=%b done=%b, required 1 1", bus.overflowError, bus.loadDone);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || bus.loadDone !== 1'b1 || bus.overflowError !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_no_write: writes=%0d done=%b ovf=%b, required 0 1 0",
               obs_q.size(), bus.loadDone, bus.overflowError);
    end
  endtask

  task automatic test_reset_midload();
    int c0, dcyc;
    logic hold_prev;
    do_reset();
    obs_q = {};
    fill_random(6, 1'b0);
    build_exp(1);
    start_load(3, c0);
    stream();
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.byteReady, bus.memWriteEnable, bus.memAddress, bus.memWriteData,
         bus.cpuHold, bus.loadDone, bus.overflowError} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%h data=%h hold=%b done=%b ovf=%b, required all 0",
               bus.byteReady, bus.memWriteEnable, bus.memAddress, bus.memWriteData,
               bus.cpuHold, bus.loadDone, bus.overflowError);
    end
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL midload_writes: %0d writes first=%h, required 1 write %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, exp_q[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    obs_q = {};
    fill_random(4, 1'b0);
    build_exp(1);
    start_load(1, c0);
    stream();
    wait_done(30, dcyc, hold_prev);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL fresh_load: %0d writes first=%h, required 1 write %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_start_ignored();
    int c0, dcyc;
    logic hold_prev;
    obs_q = {};
    fill_random(8, 1'b0);
    build_exp(2);
    start_load(2, c0);
    bus.start = 1'b1;
    bus.wordCount = 11'd5;
    stream();
    bus.start = 1'b0;
    wait_done(60, dcyc, hold_prev);
    n_cmp++;
    if (dcyc - (c0 + 1) != 10) begin
      n_fail++;
      $display("FAIL ignored_latency: %0d cycles, required 10", dcyc - (c0 + 1));
    end
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      n_fail++;
      $display("FAIL ignored_writes: %0d writes, required 2 matching scoreboard", obs_q.size());
    end
    // Re-arm from DONE
    obs_q = {};
    fill_random(4, 1'b0);
    build_exp(1);
    start_load(1, c0);
    n_cmp++;
    if (bus.loadDone !== 1'b0 || bus.cpuHold !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm: done=%b hold=%b, required 0 1", bus.loadDone, bus.cpuHold);
    end
    stream();
    wait_done(30, dcyc, hold_prev);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rearm_write: %0d writes first=%h, required 1 write %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_full();
    int c0, dcyc;
    logic hold_prev;
    obs_q = {};
    for (int i = 0; i < WC; i++) mem[i] = 32'hDEAD_BEEF;
    fill_random(4 * WC, 1'b1);
    build_exp(WC);
    start_load(WC, c0);
    stream();
    wait_done(100, dcyc, hold_prev);
    n_cmp++;
    if (obs_q.size() != WC) begin
      n_fail++;
      $display("FAIL full_count: %0d writes, required %0d", obs_q.size(), WC);
    end
    for (int i = 0; i < obs_q.size() && i < WC; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_write%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < WC; i++) begin
      n_cmp++;
      if (mem[i] !== exp_q[i][31:0]) begin
        n_fail++;
        $display("FAIL full_mem%0d: got %h, required %h", i, mem[i], exp_q[i][31:0]);
      end
    end
    n_cmp++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1][AW+31:32] !== AW'(WC - 1)) begin
      n_fail++;
      $display("FAIL full_last_addr: got %h, required %h",
               obs_q.size() > 0 ? obs_q[obs_q.size()-1][AW+31:32] : '0, AW'(WC - 1));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.wordCount = '0;
    bus.byteIn = '0;
    bus.byteValid = 1'b0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_zero_overflow();
    test_reset_midload();
    test_start_ignored();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
